spmv_sym_stream: RTL and testbench

- Streaming sparse matrix-vector engine computing y = A·x over a handshaked element stream (value, column, end-of-row, end-of-matrix).
- Supports a general mode and a symmetric mode. In symmetric mode only the upper triangle is streamed, and the lower triangle is reconstructed by scattering into an internal lower-sum array.
- x and the lower-sum array are held internally in N-deep register arrays. Row results leave on a valid/ready output stream.
- Sits between the CSR element fetcher and the result writer, replacing the fixed-depth RAM-based datapath.

---
 rtl/spmv_sym_stream.sv | 242 ++++++++++++++++++++++++
 tb/tb_spmv_sym_stream.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_sym_stream.sv
// Streaming sparse y = A*x engine with a general mode and a symmetric (upper-triangle) mode.
// Optional build macro SPMV_SATURATE_EN: accumulator additions saturate instead of wrapping.
module spmv_sym_stream #(
    parameter int N      = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_sym_mode,
    input  logic              i_x_we,
    input  logic [IDX_W-1:0]  i_x_addr,
    input  logic [DATA_W-1:0] i_x_wdata,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_val,
    input  logic [IDX_W-1:0]  i_in_col,
    input  logic              i_in_eor,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out_data,
    output logic [IDX_W-1:0]  o_out_row,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_range,
    output logic              o_err_lower
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [IDX_W:0]   NLIM     = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N-1);

    function automatic logic signed [ACC_W-1:0] f_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef SPMV_SATURATE_EN
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            f_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            f_add = s[ACC_W-1:0];
`else
        f_add = a + b;
`endif
    endfunction

    logic [1:0]               r_state;
    logic [IDX_W-1:0]         r_clr_idx;
    logic [IDX_W-1:0]         r_row;
    logic                     r_sym;
    logic                     r_first;
    logic                     r_seen_last;
    logic                     r_last_out;
    logic                     r_err_range;
    logic                     r_err_lower;

    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_val;
    logic [IDX_W-1:0]         r_s1_col;
    logic [IDX_W-1:0]         r_s1_row;
    logic                     r_s1_eor;
    logic                     r_s1_last;
    logic                     r_s1_first;
    logic                     r_s1_diag;
    logic                     r_s1_inr;
    logic signed [DATA_W-1:0] r_s1_xc;
    logic signed [DATA_W-1:0] r_s1_xr;

    logic signed [DATA_W-1:0] r_x     [N];
    logic signed [ACC_W-1:0]  r_lower [N];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_out_data;
    logic [IDX_W-1:0]         r_out_row;
    logic                     r_out_valid;

    logic                       w_stall;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_col_oob;
    logic                       w_xaddr_oob;
    logic                       w_s2_go;
    logic                       w_scatter;
    logic                       w_lower_err;
    logic signed [DATA_W-1:0]   w_xc;
    logic signed [2*DATA_W-1:0] w_pup;
    logic signed [2*DATA_W-1:0] w_plo;
    logic signed [ACC_W-1:0]    w_acc_new;
    logic signed [ACC_W-1:0]    w_result;

    // A pending, unconsumed result freezes both pipeline stages and the input.
    assign w_stall     = r_out_valid && !i_out_ready;
    assign w_in_ready  = (r_state == S_RUN) && !w_stall && !r_seen_last;
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_col_oob   = ({1'b0, i_in_col} >= NLIM);
    assign w_xaddr_oob = ({1'b0, i_x_addr} >= NLIM);
    assign w_xc        = w_col_oob ? '0 : r_x[i_in_col];

    assign w_s2_go     = r_s1_valid && !w_stall;
    assign w_pup       = r_s1_val * r_s1_xc;
    assign w_plo       = r_s1_val * r_s1_xr;
    assign w_scatter   = r_sym && r_s1_inr && !r_s1_diag && (r_s1_col > r_s1_row);
    assign w_lower_err = r_sym && r_s1_inr && (r_s1_col < r_s1_row);
    assign w_acc_new   = f_add(r_s1_first ? '0 : r_acc, ACC_W'(w_pup));
    // lower[row] only receives contributions from earlier rows, so it is final here.
    assign w_result    = r_sym ? f_add(w_acc_new, r_lower[r_s1_row]) : w_acc_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clr_idx   <= '0;
            r_row       <= '0;
            r_sym       <= 1'b0;
            r_first     <= 1'b0;
            r_seen_last <= 1'b0;
            r_last_out  <= 1'b0;
            r_err_range <= 1'b0;
            r_err_lower <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state     <= S_CLEAR;
                    r_sym       <= i_sym_mode;
                    r_clr_idx   <= '0;
                    r_row       <= '0;
                    r_first     <= 1'b1;
                    r_seen_last <= 1'b0;
                    r_last_out  <= 1'b0;
                    r_err_range <= 1'b0;
                    r_err_lower <= 1'b0;
                end
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_ROW)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_col_oob)
                            r_err_range <= 1'b1;
                        r_first <= i_in_eor || i_in_last;
                        if (i_in_last)
                            r_seen_last <= 1'b1;
                        else if (i_in_eor) begin
                            if (r_row == LAST_ROW)
                                r_err_range <= 1'b1;
                            else
                                r_row <= r_row + 1'b1;
                        end
                    end
                    if (w_s2_go && w_lower_err)
                        r_err_lower <= 1'b1;
                    if (w_s2_go && r_s1_last)
                        r_last_out <= 1'b1;
                    if (r_last_out && r_out_valid && i_out_ready)
                        r_state <= S_DRAIN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_eor   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_diag  <= 1'b0;
            r_s1_inr   <= 1'b0;
            r_s1_xc    <= '0;
            r_s1_xr    <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_val   <= i_in_val;
                r_s1_col   <= i_in_col;
                r_s1_row   <= r_row;
                r_s1_eor   <= i_in_eor || i_in_last;
                r_s1_last  <= i_in_last;
                r_s1_first <= r_first;
                r_s1_diag  <= (i_in_col == r_row);
                r_s1_inr   <= !w_col_oob;
                r_s1_xc    <= w_xc;
                r_s1_xr    <= r_x[r_row];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_x[i]     <= '0;
                r_lower[i] <= '0;
            end
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
        end else begin
            if (r_state == S_IDLE && i_x_we && !w_xaddr_oob)
                r_x[i_x_addr] <= i_x_wdata;
            if (r_state == S_CLEAR) begin
                r_lower[r_clr_idx] <= '0;
                r_acc              <= '0;
            end
            if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;
            if (w_s2_go) begin
                r_acc <= w_acc_new;
                if (w_scatter)
                    r_lower[r_s1_col] <= f_add(r_lower[r_s1_col], ACC_W'(w_plo));
                if (r_s1_eor) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_result;
                    r_out_row   <= r_s1_row;
                end
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DRAIN);
    assign o_err_range = r_err_range;
    assign o_err_lower = r_err_lower;

endmodule

// File: tb/tb_spmv_sym_stream.sv
// Bench for spmv_sym_stream: directed scenarios plus random matrices checked against a
// row-by-row arithmetic model of y = A*x (honours SPMV_SATURATE_EN like the design).
module tb_spmv_sym_stream;

    localparam int N      = 12;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef struct {
        int row;
        int col;
        int val;
        bit eor;
        bit last;
    } elem_t;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic              i_sym_mode;
    logic              i_x_we;
    logic [IDX_W-1:0]  i_x_addr;
    logic [DATA_W-1:0] i_x_wdata;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_val;
    logic [IDX_W-1:0]  i_in_col;
    logic              i_in_eor;
    logic              i_in_last;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [ACC_W-1:0]  o_out_data;
    logic [IDX_W-1:0]  o_out_row;
    logic              o_busy;
    logic              o_done;
    logic              o_err_range;
    logic              o_err_lower;

    int      gChecks;
    int      gErrors;
    elem_t   gElems[$];
    longint  gExpData[$];
    int      gExpRow[$];
    int      gX[N];
    bit      gExpErrRange;
    bit      gExpErrLower;
    bit      gGaps;
    bit      gRandReady;
    bit      gStall;

    spmv_sym_stream #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_sym_mode(i_sym_mode),
        .i_x_we(i_x_we), .i_x_addr(i_x_addr), .i_x_wdata(i_x_wdata),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_val(i_in_val),
        .i_in_col(i_in_col), .i_in_eor(i_in_eor), .i_in_last(i_in_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_row(o_out_row), .o_busy(o_busy), .o_done(o_done),
        .o_err_range(o_err_range), .o_err_lower(o_err_lower)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        gChecks++;
        if (observed != expected) begin
            gErrors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Accumulator addition as the hardware defines it: saturating or wrapping at ACC_W bits.
    function automatic longint addM(input longint a, input longint b);
        longint     s;
        logic [63:0] t;
        s = a + b;
`ifdef SPMV_SATURATE_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
`else
        t = s;
        return longint'($signed(t[31:0]));
`endif
    endfunction

    function automatic void buildExpected(input bit sym);
        longint lower[N];
        longint acc;
        longint pu;
        bit     first;
        gExpData.delete();
        gExpRow.delete();
        gExpErrRange = 1'b0;
        gExpErrLower = 1'b0;
        for (int i = 0; i < N; i++) lower[i] = 0;
        acc   = 0;
        first = 1'b1;
        foreach (gElems[i]) begin
            pu = 0;
            if (gElems[i].col < N) pu = longint'(gElems[i].val) * longint'(gX[gElems[i].col]);
            else gExpErrRange = 1'b1;
            acc   = addM(first ? 64'sd0 : acc, pu);
            first = 1'b0;
            if (sym && gElems[i].col < gElems[i].row) gExpErrLower = 1'b1;
            if (sym && gElems[i].col < N && gElems[i].col > gElems[i].row)
                lower[gElems[i].col] = addM(lower[gElems[i].col],
                    longint'(gElems[i].val) * longint'(gX[gElems[i].row]));
            if (gElems[i].eor || gElems[i].last) begin
                gExpData.push_back(sym ? addM(acc, lower[gElems[i].row]) : acc);
                gExpRow.push_back(gElems[i].row);
                first = 1'b1;
            end
        end
    endfunction

    function automatic void addElem(input int r, input int c, input int v, input bit e, input bit l);
        elem_t el;
        el.row = r; el.col = c; el.val = v; el.eor = e; el.last = l;
        gElems.push_back(el);
    endfunction

    // Random matrix: symmetric mode streams the diagonal plus random upper entries per row.
    function automatic void genMatrix(input bit sym, input int nRows);
        int cols[$];
        gElems.delete();
        for (int i = 0; i < N; i++) gX[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int r = 0; r < nRows; r++) begin
            cols.delete();
            for (int c = 0; c < N; c++) begin
                if (sym && c == r) cols.push_back(c);
                else if ((!sym || c > r) && $urandom_range(0, 3) == 0) cols.push_back(c);
            end
            if (cols.size() == 0) cols.push_back(r);
            foreach (cols[k])
                addElem(r, cols[k], int'($urandom_range(0, 65535)) - 32768,
                        k == cols.size() - 1, (k == cols.size() - 1) && (r == nRows - 1));
        end
    endfunction

    task automatic applyStimulus();
        int i = 0;
        int cycles = 0;
        while (i < gElems.size() && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (gGaps && $urandom_range(0, 3) == 0) begin
                i_in_valid = 1'b0;
            end else begin
                i_in_valid = 1'b1;
                i_in_val   = DATA_W'(gElems[i].val);
                i_in_col   = IDX_W'(gElems[i].col);
                i_in_eor   = gElems[i].eor;
                i_in_last  = gElems[i].last;
                #1;
                if (o_in_ready) i++;
            end
        end
        if (i < gElems.size()) checkOutput("drvTimeout", longint'(i), longint'(gElems.size()));
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic collectResults();
        int idx = 0;
        int cycles = 0;
        int stallCnt = 0;
        bit gotDone = 1'b0;
        while ((idx < gExpData.size() || !gotDone) && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (gStall && stallCnt < 5) i_out_ready = 1'b0;
            else if (gRandReady) i_out_ready = ($urandom_range(0, 2) != 0);
            else i_out_ready = 1'b1;
            #1;
            if (gStall && stallCnt < 5 && o_out_valid) begin
                checkOutput("stallInReady", longint'(o_in_ready), 0);
                checkOutput("stallData", longint'($signed(o_out_data)), gExpData[0]);
                stallCnt++;
            end
            if (o_done) gotDone = 1'b1;
            if (o_out_valid && i_out_ready) begin
                if (idx < gExpData.size()) begin
                    checkOutput("outData", longint'($signed(o_out_data)), gExpData[idx]);
                    checkOutput("outRow", longint'(o_out_row), longint'(gExpRow[idx]));
                end else begin
                    checkOutput("extraOut", longint'(idx), longint'(gExpData.size()));
                end
                idx++;
            end
        end
        checkOutput("outCount", longint'(idx), longint'(gExpData.size()));
        checkOutput("donePulse", longint'(gotDone), 1);
        i_out_ready = 1'b1;
    endtask

    task automatic writeX();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            i_x_we    = 1'b1;
            i_x_addr  = IDX_W'(i);
            i_x_wdata = DATA_W'(gX[i]);
        end
        @(negedge clk);
        i_x_we = 1'b0;
    endtask

    task automatic runPass(input bit sym, input bit gaps, input bit randReady, input bit stall);
        buildExpected(sym);
        gGaps      = gaps;
        gRandReady = randReady;
        gStall     = stall;
        writeX();
        @(negedge clk);
        i_start    = 1'b1;
        i_sym_mode = sym;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        checkOutput("busyAfterStart", longint'(o_busy), 1);
        checkOutput("errRangeCleared", longint'(o_err_range), 0);
        checkOutput("errLowerCleared", longint'(o_err_lower), 0);
        fork
            applyStimulus();
            collectResults();
        join
        @(negedge clk);
        #1;
        checkOutput("idleAfterDone", longint'(o_busy), 0);
        checkOutput("errRange", longint'(o_err_range), longint'(gExpErrRange));
        checkOutput("errLower", longint'(o_err_lower), longint'(gExpErrLower));
    endtask

    task automatic smallX(input int x0, input int x1, input int x2);
        for (int i = 0; i < N; i++) gX[i] = 0;
        gX[0] = x0;
        gX[1] = x1;
        gX[2] = x2;
    endtask

    initial begin
        gChecks     = 0;
        gErrors     = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_sym_mode  = 1'b0;
        i_x_we      = 1'b0;
        i_x_addr    = '0;
        i_x_wdata   = '0;
        i_in_valid  = 1'b0;
        i_in_val    = '0;
        i_in_col    = '0;
        i_in_eor    = 1'b0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstOutValid", longint'(o_out_valid), 0);
        checkOutput("rstBusy", longint'(o_busy), 0);
        checkOutput("rstInReady", longint'(o_in_ready), 0);
        checkOutput("rstDone", longint'(o_done), 0);
        checkOutput("rstErrRange", longint'(o_err_range), 0);
        checkOutput("rstErrLower", longint'(o_err_lower), 0);
        checkOutput("rstOutData", longint'(o_out_data), 0);
        rst_n = 1'b1;

        // Small symmetric and general examples, then the same symmetric one under backpressure.
        smallX(1, 2, 0);
        gElems.delete();
        addElem(0, 0, 2, 1'b0, 1'b0);
        addElem(0, 1, 3, 1'b1, 1'b0);
        addElem(1, 1, 4, 1'b1, 1'b1);
        runPass(1'b1, 1'b0, 1'b0, 1'b0);
        runPass(1'b0, 1'b0, 1'b0, 1'b0);
        runPass(1'b1, 1'b0, 1'b0, 1'b1);

        // Out-of-range column and a below-diagonal symmetric entry.
        smallX(3, -5, 7);
        gElems.delete();
        addElem(0, 0, 1, 1'b0, 1'b0);
        addElem(0, 13, 5, 1'b1, 1'b0);
        addElem(1, 0, 2, 1'b0, 1'b0);
        addElem(1, 1, 3, 1'b1, 1'b1);
        runPass(1'b1, 1'b0, 1'b0, 1'b0);

        // Large products on one row exercise saturation or wrap.
        smallX(32767, 32767, 32767);
        gElems.delete();
        addElem(0, 0, 32767, 1'b0, 1'b0);
        addElem(0, 1, 32767, 1'b0, 1'b0);
        addElem(0, 2, 32767, 1'b1, 1'b1);
        runPass(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a row, after a scatter into lower[3].
        smallX(9, 4, 2);
        writeX();
        @(negedge clk);
        i_start    = 1'b1;
        i_sym_mode = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        gElems.delete();
        addElem(0, 0, 5, 1'b0, 1'b0);
        addElem(0, 3, 6, 1'b1, 1'b0);
        addElem(1, 1, 7, 1'b0, 1'b0);
        gGaps = 1'b0;
        applyStimulus();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midRstOutValid", longint'(o_out_valid), 0);
        checkOutput("midRstBusy", longint'(o_busy), 0);
        checkOutput("midRstInReady", longint'(o_in_ready), 0);
        rst_n = 1'b1;
        genMatrix(1'b1, N);
        runPass(1'b1, 1'b1, 1'b1, 1'b0);

        for (int p = 0; p < 8; p++) begin
            genMatrix(p[0], int'($urandom_range(1, N)));
            runPass(p[0], 1'b1, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", gChecks, gErrors);
        $finish;
    end

endmodule
